// File: rtl/logs_sweep_sched.sv
// logs_sweep_sched: sweeps the logistic-map parameter r across [INITIAL_R, 4.0).
// For each r value it discards SETTLE_LEN map iterations, forwards PLAY_LEN
// iterations to the oscillators, then spends one ADVANCE cycle restarting the
// map iterator and stepping r (coarse steps below 3.0, fine steps above).
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset
//   next_ready : pulse, map iterator has a new x
//   pause      : level, freezes sweep progress in SETTLE/PLAY
//   step_req   : pulse, abandon current r and advance now
//   r          : current r, 2.FRAC fixed point (registered)
//   x_accept   : combinational, load current x into an oscillator slot
//   restart    : pulse during ADVANCE, iterator reloads its seed
//   wrapped    : pulse, r wrapped back to INITIAL_R
//   state      : debug state (SETTLE=0, PLAY=1, ADVANCE=2)
module logs_sweep_sched #(
    parameter int unsigned FRAC       = 8,
    parameter int unsigned SETTLE_LEN = 64,
    parameter int unsigned PLAY_LEN   = 1000,
    parameter int unsigned INITIAL_R  = (1 << FRAC) | (1 << (FRAC - 4))
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            next_ready,
    input  logic            pause,
    input  logic            step_req,
    output logic [FRAC+1:0] r,
    output logic            x_accept,
    output logic            restart,
    output logic            wrapped,
    output logic [1:0]      state
);

    localparam int unsigned RW      = FRAC + 2;
    localparam int unsigned MAX_LEN = (SETTLE_LEN > PLAY_LEN) ? SETTLE_LEN : PLAY_LEN;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        PLAY    = 2'd1,
        ADVANCE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    r_q, r_d;
    logic             restart_q, restart_d;
    logic             wrapped_q, wrapped_d;

    // Candidate next r: one extra bit catches the overflow past 4.0.
    logic [RW:0]      r_sum;
    logic [RW-1:0]    r_inc;
    logic             count_en;

    assign r_inc    = (r_q[RW-1:RW-2] < 2'b11) ? RW'(4) : RW'(1);
    assign r_sum    = {1'b0, r_q} + {1'b0, r_inc};
    assign count_en = next_ready & ~pause;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            r_q       <= RW'(INITIAL_R);
            restart_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            restart_q <= restart_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Next-state logic; restart is registered on entry so it covers exactly the ADVANCE cycle,
    // and wrapped is registered with the new r so it lands in the following cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        restart_d = 1'b0;
        wrapped_d = 1'b0;
        case (state_q)
            SETTLE: begin
                if (step_req) begin
                    state_d   = ADVANCE;
                    cnt_d     = '0;
                    restart_d = 1'b1;
                end else if (count_en) begin
                    if (cnt_q == CNT_W'(SETTLE_LEN - 1)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                if (step_req || (count_en && cnt_q == CNT_W'(PLAY_LEN - 1))) begin
                    state_d   = ADVANCE;
                    cnt_d     = '0;
                    restart_d = 1'b1;
                end else if (count_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ADVANCE: begin
                state_d = SETTLE;
                cnt_d   = '0;
                if (r_sum[RW]) begin
                    r_d       = RW'(INITIAL_R);
                    wrapped_d = 1'b1;
                end else begin
                    r_d = r_sum[RW-1:0];
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Zero-latency accept so the oscillator captures x in the same cycle it is offered.
    assign x_accept = next_ready & ~pause & ~reset & (state_q == PLAY);

    assign r       = r_q;
    assign restart = restart_q;
    assign wrapped = wrapped_q;
    assign state   = state_q;

endmodule

// File: doc/logs_sweep_sched.md
LOGS_SWEEP_SCHED -- requirements
Module: logs_sweep_sched

Interface
REQ-001 SHALL have parameter FRAC, default 8: fractional bits of r (r is 2.FRAC fixed point).
REQ-002 SHALL have parameter SETTLE_LEN, default 64: map iterations discarded after each r change.
REQ-003 SHALL have parameter PLAY_LEN, default 1000: map iterations forwarded to the oscillators per r value.
REQ-004 SHALL have parameter INITIAL_R, default (1<<FRAC)|(1<<(FRAC-4)), i.e. 1.0625 (0x110 at FRAC=8).
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 next_ready  input  1  one-cycle pulse from the map iterator: a new x is valid.
REQ-008 pause  input  1  level; freezes sweep progress while high.
REQ-009 step_req  input  1  one-cycle pulse; abandons the current r and advances immediately.
REQ-010 r  output  FRAC+2  current r value driven to the map iterator (registered).
REQ-011 x_accept  output  1  high when the current x is to be loaded into an oscillator frequency slot.
REQ-012 restart  output  1  one-cycle pulse; map iterator reloads its seed x.
REQ-013 wrapped  output  1  one-cycle pulse; sweep wrapped from top of range back to INITIAL_R.
REQ-014 state  output  2  debug state: SETTLE=0, PLAY=1, ADVANCE=2; 3 never occurs.

Function
REQ-015 SHALL implement FSM states SETTLE, PLAY, ADVANCE, with one iteration counter cnt of width $clog2(max(SETTLE_LEN,PLAY_LEN)).
REQ-016 SETTLE: on next_ready with pause low, cnt increments; at cnt==SETTLE_LEN-1 it goes to PLAY with cnt<=0.
REQ-017 PLAY: on next_ready with pause low, cnt increments; at cnt==PLAY_LEN-1 it goes to ADVANCE with cnt<=0.
REQ-018 x_accept SHALL be combinational: next_ready AND state==PLAY AND pause low, so zero latency from next_ready.
REQ-019 ADVANCE SHALL last exactly one cycle, assert restart for that cycle, update r, then return to SETTLE with cnt=0.
REQ-020 r update in ADVANCE: increment is 4 LSB if r[FRAC+1:FRAC] < 2'b11, else 1 LSB.
REQ-021 Wrap: if r+increment >= 4.0 (overflows FRAC+2 bits), r SHALL become INITIAL_R and wrapped SHALL pulse in that cycle; no wrap, no pulse.
REQ-022 pause high: cnt and state frozen in SETTLE/PLAY; next_ready pulses dropped and never counted later; ADVANCE still completes.
REQ-023 step_req in SETTLE or PLAY: next state is ADVANCE regardless of cnt or pause; step_req during ADVANCE is ignored.
REQ-024 step_req and next_ready in the same PLAY cycle: x_accept still asserted for that x, then ADVANCE.
REQ-025 next_ready during ADVANCE: ignored, neither counted nor accepted.
REQ-026 restart, wrapped and x_accept SHALL never be high in the same cycle.

Reset
REQ-027 With reset high, the next edge SHALL set state=SETTLE, cnt=0, r=INITIAL_R, restart=0, wrapped=0.
REQ-028 x_accept SHALL be 0 while reset is high.
REQ-029 Reset overrides step_req, pause and next_ready in the same cycle, including mid-PLAY and mid-ADVANCE.

Verification (SETTLE_LEN=4, PLAY_LEN=8, FRAC=8)
REQ-030 Reset, then 4 next_ready pulses -> x_accept stays 0; state=PLAY after the 4th; r=0x110.
REQ-031 Continuing, 8 next_ready pulses -> 8 x_accept pulses, then one ADVANCE cycle with restart=1; then r=0x114 and state=SETTLE.
REQ-032 Force r to 0x2FC, advance -> r=0x300; advance -> 0x301; from 0x3FF, advance -> r=0x110, wrapped=1 for one cycle.
REQ-033 pause high in PLAY at cnt=3 for 5 next_ready pulses -> no x_accept, cnt stays 3; pause low -> 5 more pulses reach ADVANCE.
REQ-034 step_req in SETTLE at cnt=2 -> ADVANCE next cycle, r advances; step_req with next_ready in PLAY -> x_accept=1 that cycle, then ADVANCE.
REQ-035 Reset mid-PLAY at cnt=5 with r=0x200 -> r=0x110, state=SETTLE, no restart or wrapped pulse.
